// File: rtl/counter_timer_seq.sv
// Interval sequencer: plays back NSLOT programmed intervals as one-shot
// down-count periods on an attached counter_timer_low core.
module counter_timer_seq #(
  parameter int unsigned IDX_W = 2
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             slot_we,
  input  logic [IDX_W-1:0] slot_idx,
  input  logic [31:0]      slot_di,
  input  logic             ctrl_we,
  input  logic [31:0]      ctrl_di,
  output logic [31:0]      status_do,
  output logic [3:0]       ct_val_we,
  output logic [31:0]      ct_val_di,
  output logic             ct_cfg_we,
  output logic [31:0]      ct_cfg_di,
  input  logic             ct_stop_in,
  output logic             seq_step,
  output logic [IDX_W-1:0] seq_idx,
  output logic             irq
);

  localparam int unsigned NSLOT  = 1 << IDX_W;
  localparam int unsigned DW     = 32;
  localparam logic [DW-1:0] CFG_OFF     = 32'h0;
  localparam logic [DW-1:0] CFG_ONESHOT = 32'h3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_SETTLE, S_WAIT, S_STEP, S_ABORT
  } state_t;

  state_t           state, state_nx;
  logic [DW-1:0]    slots [NSLOT];
  logic [IDX_W-1:0] cur_idx, cur_idx_nx, last;
  logic             done, done_nx, loop_en, irq_ena;

  logic start_req, abort_req, busy, at_last;
  logic unused_ctrl;

  assign start_req   = ctrl_we && ctrl_di[0];
  assign abort_req   = ctrl_we && !ctrl_di[0];
  assign busy        = (state != S_IDLE);
  assign at_last     = (cur_idx == last);
  assign unused_ctrl = ^{ctrl_di[DW-1:4+IDX_W], ctrl_di[3]};

  // State register with the run-time counters
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cur_idx <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cur_idx <= cur_idx_nx;
      done    <= done_nx;
    end
  end

  // Control fields update on every ctrl write, busy or not
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      loop_en <= 1'b0;
      irq_ena <= 1'b0;
      last    <= '0;
    end else if (ctrl_we) begin
      loop_en <= ctrl_di[1];
      irq_ena <= ctrl_di[2];
      last    <= ctrl_di[4 +: IDX_W];
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NSLOT); i++) slots[i] <= '0;
    end else if (slot_we) begin
      slots[slot_idx] <= slot_di;
    end
  end

  // Next-state: stale stop is masked by SETTLE; abort overrides everything busy
  always_comb begin
    state_nx   = state;
    cur_idx_nx = cur_idx;
    done_nx    = done;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          cur_idx_nx = '0;
          done_nx    = 1'b0;
          state_nx   = S_LOAD;
        end
      end
      S_LOAD:   state_nx = S_ARM;
      S_ARM:    state_nx = S_SETTLE;
      S_SETTLE: state_nx = S_WAIT;
      S_WAIT:   if (ct_stop_in) state_nx = S_STEP;
      S_STEP: begin
        if (!at_last) begin
          cur_idx_nx = cur_idx + IDX_W'(1);
          state_nx   = S_LOAD;
        end else if (loop_en) begin
          cur_idx_nx = '0;
          state_nx   = S_LOAD;
        end else begin
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_ABORT:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (busy && state != S_ABORT && abort_req) begin
      state_nx   = S_ABORT;
      cur_idx_nx = cur_idx;
      done_nx    = done;
    end
  end

  // Output decode of the registered state
  always_comb begin
    ct_val_we = 4'h0;
    ct_val_di = '0;
    ct_cfg_we = 1'b0;
    ct_cfg_di = CFG_OFF;
    seq_step  = 1'b0;
    irq       = 1'b0;
    case (state)
      S_LOAD: begin
        ct_val_we = 4'hF;
        ct_val_di = slots[cur_idx];
        ct_cfg_we = 1'b1;
      end
      S_ARM: begin
        ct_cfg_we = 1'b1;
        ct_cfg_di = CFG_ONESHOT;
      end
      S_STEP: begin
        seq_step = 1'b1;
        irq      = irq_ena && at_last;
      end
      S_ABORT:  ct_cfg_we = 1'b1;
      default: ;
    endcase
    seq_idx   = cur_idx;
    status_do = '0;
    status_do[0] = busy;
    status_do[1] = done;
    status_do[2] = loop_en;
    status_do[3] = irq_ena;
    status_do[4 +: IDX_W] = last;
    status_do[8 +: IDX_W] = cur_idx;
  end

endmodule
